kmer_window_buf: RTL and testbench

KMER_WINDOW_BUF -- requirements
Module: kmer_window_buf

---
 rtl/kmer_pkg.sv | 8 +
 rtl/kmer_window_mem.sv | 35 +++
 rtl/kmer_window_buf.sv | 86 ++++++++
 tb/tb_kmer_window_buf.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kmer_pkg.sv
// Shared k-mer encoding constants: 2-bit bases, 60-base default k-mer.
package kmer_pkg;

    localparam int unsigned BASE_W         = 2;
    localparam int unsigned KMER_BASES     = 60;
    localparam int unsigned KMER_W_DEFAULT = BASE_W * KMER_BASES;

endpackage

// File: rtl/kmer_window_mem.sv
// DEPTH x KMER_W register array: one synchronous write port, two async read ports.
module kmer_window_mem
    import kmer_pkg::*;
#(
    parameter  int unsigned KMER_W = KMER_W_DEFAULT,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [KMER_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [KMER_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [KMER_W-1:0] rd_data_b
);

    logic [KMER_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/kmer_window_buf.sv
// K-mer window FIFO with first-word fall-through head, random peek and sticky overflow flag.
module kmer_window_buf
    import kmer_pkg::*;
#(
    parameter  int unsigned KMER_W = KMER_W_DEFAULT,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KMER_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [KMER_W-1:0] out_data,
    input  logic [AW-1:0]     peek_ofs,
    output logic [KMER_W-1:0] peek_data,
    output logic              peek_valid,
    input  logic              flush,
    output logic [AW:0]       count,
    output logic              ovf_sticky
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] peek_addr;
    logic          push;
    logic          pop;

    assign in_ready   = (count < FULL_CNT);
    assign out_valid  = (count != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    // DEPTH is a power of two, so AW-bit addition wraps mod DEPTH for free
    assign peek_addr  = rd_ptr + peek_ofs;
    assign peek_valid = ({1'b0, peek_ofs} < count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (in_valid && !in_ready) begin
                ovf_sticky <= 1'b1;
            end
        end
    end

    // flush blocks the write so storage keeps its old contents
    kmer_window_mem #(
        .KMER_W (KMER_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push && !flush),
        .wr_addr   (wr_ptr),
        .wr_data   (in_data),
        .rd_addr_a (rd_ptr),
        .rd_data_a (out_data),
        .rd_addr_b (peek_addr),
        .rd_data_b (peek_data)
    );

endmodule

// File: tb/tb_kmer_window_buf.sv
// Directed scenarios on a DEPTH=4 instance plus randomized scoreboard run on a DEPTH=8 instance.
module tb_kmer_window_buf;

    localparam int unsigned W = 120;

    logic clk;
    int   n_cmp = 0;
    int   n_err = 0;
    logic a_done = 1'b0;
    logic b_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance for directed checks
    logic          a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic          a_peek_valid, a_flush, a_ovf;
    logic [W-1:0]  a_in_data, a_out_data, a_peek_data;
    logic [1:0]    a_peek_ofs;
    logic [2:0]    a_count;

    kmer_window_buf #(.KMER_W(W), .DEPTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (a_rst_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data),
        .peek_ofs   (a_peek_ofs),
        .peek_data  (a_peek_data),
        .peek_valid (a_peek_valid),
        .flush      (a_flush),
        .count      (a_count),
        .ovf_sticky (a_ovf)
    );

    // DEPTH=8 instance for randomized traffic
    logic          b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic          b_peek_valid, b_flush, b_ovf;
    logic [W-1:0]  b_in_data, b_out_data, b_peek_data;
    logic [2:0]    b_peek_ofs;
    logic [3:0]    b_count;

    kmer_window_buf #(.KMER_W(W), .DEPTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (b_rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .peek_ofs   (b_peek_ofs),
        .peek_data  (b_peek_data),
        .peek_valid (b_peek_valid),
        .flush      (b_flush),
        .count      (b_count),
        .ovf_sticky (b_ovf)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_kmer();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Directed sequence on the DEPTH=4 instance
    initial begin
        logic [W-1:0] ka [4];
        logic [W-1:0] fk [6];
        logic [W-1:0] e_k, g_k, h_k, x1, x2, x3;
        logic [W-1:0] q [$];

        for (int i = 0; i < 4; i++) ka[i] = rand_kmer();
        for (int i = 0; i < 6; i++) fk[i] = rand_kmer();
        e_k = rand_kmer(); g_k = rand_kmer(); h_k = rand_kmer();
        x1 = rand_kmer(); x2 = rand_kmer(); x3 = rand_kmer();

        a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        a_peek_ofs = '0; a_flush = 1'b0;
        #2;
        chk("rst_in_ready",   a_in_ready,   1);
        chk("rst_out_valid",  a_out_valid,  0);
        chk("rst_peek_valid", a_peek_valid, 0);
        chk("rst_out_data",   a_out_data,   0);
        chk("rst_peek_data",  a_peek_data,  0);
        chk("rst_count",      a_count,      0);
        chk("rst_ovf",        a_ovf,        0);
        #10 a_rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_data = ka[i];
            tick();
            if (i == 0) begin
                chk("lat_out_valid", a_out_valid, 1);
                chk("lat_out_data",  a_out_data,  ka[0]);
                chk("lat_count",     a_count,     1);
            end
        end
        a_in_valid = 1'b0;
        chk("full_count",    a_count,    4);
        chk("full_in_ready", a_in_ready, 0);
        chk("full_head",     a_out_data, ka[0]);
        a_peek_ofs = 2'd3;
        #1;
        chk("peek3_data",  a_peek_data,  ka[3]);
        chk("peek3_valid", a_peek_valid, 1);
        a_peek_ofs = 2'd0;

        a_in_valid = 1'b1; a_in_data = e_k;
        tick();
        a_in_valid = 1'b0;
        chk("ovf_set",   a_ovf,      1);
        chk("ovf_count", a_count,    4);
        chk("ovf_head",  a_out_data, ka[0]);

        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("pop1_head",     a_out_data, ka[1]);
        chk("pop1_in_ready", a_in_ready, 1);
        chk("pop1_count",    a_count,    3);

        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("pop2_count", a_count,    2);
        chk("pop2_head",  a_out_data, ka[2]);
        q = '{ka[2], ka[3]};

        for (int i = 0; i < 6; i++) begin
            chk("wrap_head", a_out_data, q[0]);
            a_in_valid = 1'b1; a_in_data = fk[i]; a_out_ready = 1'b1;
            tick();
            void'(q.pop_front());
            q.push_back(fk[i]);
            chk("wrap_count", a_count, 2);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        chk("wrap_final_head", a_out_data, q[0]);

        a_in_valid = 1'b1; a_in_data = g_k;
        tick();
        a_in_valid = 1'b0;
        chk("pre_flush_count", a_count, 3);
        chk("pre_flush_ovf",   a_ovf,   1);

        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = h_k; a_out_ready = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        chk("flush_count",     a_count,     0);
        chk("flush_out_valid", a_out_valid, 0);
        chk("flush_ovf",       a_ovf,       0);
        chk("flush_in_ready",  a_in_ready,  1);
        // Entry 0 last held fk[4]; flush must neither clear it nor let h_k in
        chk("flush_stale",     a_out_data,  fk[4]);

        a_in_valid = 1'b1; a_in_data = x1;
        tick();
        chk("post_flush_head",  a_out_data, x1);
        chk("post_flush_count", a_count,    1);
        a_in_data = x2;
        tick();
        a_in_valid = 1'b0;
        chk("post_flush_count2", a_count, 2);

        #3 a_rst_n = 1'b0;
        #1;
        chk("mid_rst_count",     a_count,     0);
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_in_ready",  a_in_ready,  1);
        chk("mid_rst_out_data",  a_out_data,  0);
        chk("mid_rst_peek_data", a_peek_data, 0);
        chk("mid_rst_ovf",       a_ovf,       0);
        #4 a_rst_n = 1'b1;
        tick();
        a_in_valid = 1'b1; a_in_data = x3;
        tick();
        a_in_valid = 1'b0;
        chk("after_rst_head",  a_out_data,  x3);
        chk("after_rst_valid", a_out_valid, 1);
        chk("after_rst_count", a_count,     1);
        a_peek_ofs = 2'd1;
        #1;
        chk("after_rst_peek_valid", a_peek_valid, 0);
        chk("after_rst_peek_data",  a_peek_data,  0);
        a_done = 1'b1;
    end

    // Randomized stimulus on the DEPTH=8 instance
    logic rnd_run = 1'b0;

    initial begin
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        b_peek_ofs = '0; b_flush = 1'b0;
        #12 b_rst_n = 1'b1;
        rnd_run = 1'b1;
        repeat (10000) begin
            tick();
            b_in_valid  = ($urandom_range(0, 9) < 6);
            b_out_ready = ($urandom_range(0, 1) == 1);
            b_flush     = ($urandom_range(0, 63) == 0);
            b_in_data   = rand_kmer();
            b_peek_ofs  = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        #1;
        rnd_run = 1'b0;
        b_done  = 1'b1;
    end

    // Monitor: reference queue of live entries, compared at each negedge
    logic [W-1:0] sb [$];
    logic         m_ovf = 1'b0;
    int unsigned  sz;

    always @(negedge clk) begin
        if (rnd_run) begin
            sz = sb.size();
            chk("rnd_count",      b_count,      sz);
            chk("rnd_in_ready",   b_in_ready,   sz < 8);
            chk("rnd_out_valid",  b_out_valid,  sz > 0);
            chk("rnd_ovf",        b_ovf,        m_ovf);
            chk("rnd_peek_valid", b_peek_valid, b_peek_ofs < sz);
            if (sz > 0) chk("rnd_out_data", b_out_data, sb[0]);
            if (b_peek_ofs < sz) chk("rnd_peek_data", b_peek_data, sb[b_peek_ofs]);
            if (b_flush) begin
                sb.delete();
                m_ovf = 1'b0;
            end else begin
                if (b_in_valid && sz == 8) m_ovf = 1'b1;
                if (b_out_ready && sz > 0) void'(sb.pop_front());
                if (b_in_valid && sz < 8) sb.push_back(b_in_data);
            end
        end
    end

    initial begin
        wait (a_done && b_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
